// File: rtl/sound_tone_player.sv
// Square-wave tone player: phase-accumulator DDS driving a speaker pin and an amplitude word,
// with a half-volume release tail. Define SOUND_OCTAVE_CHIRP_EN to step the tone up an octave after CHIRP_CYCLES.
module sound_tone_player #(
    parameter int                  ACC_W            = 32,
    parameter int                  FREQ_W           = 10,
    parameter int                  PHASE_INC_PER_HZ = 86,
    parameter int                  SAMPLE_W         = 8,
    parameter logic [SAMPLE_W-1:0] AMP              = 8'd200,
    parameter int                  TAIL_CYCLES      = 5000000,
    parameter int                  CHIRP_CYCLES     = 25000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_sound,
    input  logic [FREQ_W-1:0]   sound_freq,
    output logic                speaker_bit,
    output logic [SAMPLE_W-1:0] audio_out,
    output logic                busy
);

    localparam int TAIL_W = 26;
    localparam logic [TAIL_W-1:0] TAIL_LOAD = TAIL_W'(TAIL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, TONE, TAIL} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic [TAIL_W-1:0]  tail_q, tail_d;
    logic               en_q;
    logic               rise, fall;
    logic [ACC_W-1:0]   inc_base, inc;

    assign rise     = enable_sound & ~en_q;
    assign fall     = ~enable_sound & en_q;
    assign inc_base = ACC_W'(freq_q) * ACC_W'(PHASE_INC_PER_HZ);

`ifdef SOUND_OCTAVE_CHIRP_EN
    localparam int CHIRP_W = $clog2(CHIRP_CYCLES + 1);

    logic [CHIRP_W-1:0] chirp_q, chirp_d;
    logic               chirp_hit;

    // The counter is only cleared on TONE entry, so a chirp that fired in TONE carries into TAIL.
    assign chirp_hit = (chirp_q == CHIRP_W'(CHIRP_CYCLES));
    assign inc       = chirp_hit ? (inc_base << 1) : inc_base;

    always_comb begin
        chirp_d = chirp_q;
        if (state_d == TONE && state_q != TONE) begin
            chirp_d = '0;
        end else if (state_q == TONE && !chirp_hit) begin
            chirp_d = chirp_q + CHIRP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chirp_q <= '0;
        end else begin
            chirp_q <= chirp_d;
        end
    end
`else
    assign inc = inc_base;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        freq_d  = freq_q;
        tail_d  = tail_q;
        case (state_q)
            IDLE: begin
                acc_d = '0;
                if (rise) begin
                    freq_d  = sound_freq;
                    state_d = TONE;
                end
            end
            TONE: begin
                acc_d = acc_q + inc;
                if (fall) begin
                    tail_d  = TAIL_LOAD;
                    state_d = TAIL;
                end
            end
            TAIL: begin
                // A retrigger wins over the tail running out on the same cycle.
                if (rise) begin
                    freq_d  = sound_freq;
                    acc_d   = '0;
                    state_d = TONE;
                end else if (tail_q == '0) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end else begin
                    acc_d  = acc_q + inc;
                    tail_d = tail_q - TAIL_W'(1);
                end
            end
            default: begin
                acc_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            freq_q  <= '0;
            tail_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            freq_q  <= freq_d;
            tail_q  <= tail_d;
            en_q    <= enable_sound;
        end
    end

    assign busy        = (state_q != IDLE);
    assign speaker_bit = busy & acc_q[ACC_W-1];
    assign audio_out   = !speaker_bit      ? '0  :
                         (state_q == TONE) ? AMP : (AMP >> 1);

endmodule

// File: tb/tb_sound_tone_player.sv
// Bench for sound_tone_player: directed vector table, hand sequences for tail/retrigger/reset corners,
// then random stimulus against a cycle-count based reference model.
module tb_sound_tone_player;

    localparam int INC_HZ  = 1 << 26;
    localparam int TAIL_N  = 10;
    localparam int CHIRP_N = 32;
`ifdef SOUND_OCTAVE_CHIRP_EN
    localparam bit CHIRP = 1'b1;
`else
    localparam bit CHIRP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable_sound;
    logic [9:0] sound_freq;
    logic       speaker_bit;
    logic [7:0] audio_out;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    sound_tone_player #(
        .ACC_W(32), .FREQ_W(10), .PHASE_INC_PER_HZ(INC_HZ), .SAMPLE_W(8),
        .AMP(8'd200), .TAIL_CYCLES(TAIL_N), .CHIRP_CYCLES(CHIRP_N)
    ) dut (
        .clk(clk), .reset(reset), .enable_sound(enable_sound), .sound_freq(sound_freq),
        .speaker_bit(speaker_bit), .audio_out(audio_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle / 1 tone / 2 tail, counted in whole clock cycles.
    int          m_mode, m_tail;
    bit          m_prev;
    longint unsigned m_f, m_t, m_te;

    task automatic model_edge(bit r, bit e, int sf);
        bit rise, fall;
        if (r) begin
            m_mode = 0; m_f = 0; m_t = 0; m_te = 0; m_tail = 0; m_prev = 0;
        end else begin
            rise = e && !m_prev;
            fall = !e && m_prev;
            case (m_mode)
                0: if (rise) begin m_f = sf; m_t = 0; m_te = 0; m_mode = 1; end
                1: begin
                    m_t++;
                    if (fall) begin m_mode = 2; m_tail = TAIL_N; end
                end
                default: begin
                    if (rise) begin m_f = sf; m_t = 0; m_te = 0; m_mode = 1; end
                    else if (m_tail == 1) m_mode = 0;
                    else begin m_tail--; m_te++; end
                end
            endcase
            m_prev = e;
        end
    endtask

    // Accumulated phase, in units of one base increment.
    function automatic longint unsigned model_units();
        longint unsigned u;
        if (CHIRP) begin
            u = (m_t <= CHIRP_N) ? m_t : (2 * m_t - CHIRP_N);
            u += m_te * ((m_t >= CHIRP_N) ? 2 : 1);
        end else begin
            u = m_t + m_te;
        end
        return u;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check3(string tag, int e_spk, int e_aud, int e_busy);
        chk({tag, ".speaker_bit"}, int'(speaker_bit), e_spk);
        chk({tag, ".audio_out"}, int'(audio_out), e_aud);
        chk({tag, ".busy"}, int'(busy), e_busy);
    endtask

    task automatic check_model(string tag);
        longint unsigned ph;
        int spk;
        ph  = model_units() * m_f * longint'(INC_HZ);
        spk = (m_mode != 0) ? int'((ph >> 31) & 64'd1) : 0;
        check3(tag, spk, spk == 0 ? 0 : (m_mode == 1 ? 200 : 100), m_mode != 0);
    endtask

    task automatic step(bit r, bit e, int sf);
        reset        = r;
        enable_sound = e;
        sound_freq   = 10'(sf);
        @(posedge clk);
        model_edge(r, e, sf);
        #1;
    endtask

    typedef struct {
        bit rst;
        bit en;
        int sf;
        int spk;
        int aud;
        int busy;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int spk;
        bit en_r;
        reset = 1'b1; enable_sound = 1'b0; sound_freq = '0;

        // Freq 4: 16-cycle period, freq change mid-tone ignored, fall at k=41 then 10 tail cycles.
        tbl.push_back('{rst: 1, en: 0, sf: 0, spk: 0, aud: 0, busy: 0});
        tbl.push_back('{rst: 0, en: 1, sf: 4, spk: 0, aud: 0, busy: 1});
        for (int k = 1; k <= 40; k++) begin
            spk = (k % 16 >= 8) ? 1 : 0;
            tbl.push_back('{rst: 0, en: 1, sf: (k < 20) ? 4 : 8, spk: spk, aud: spk * 200, busy: 1});
        end
        for (int k = 41; k <= 50; k++) begin
            spk = (k % 16 >= 8) ? 1 : 0;
            tbl.push_back('{rst: 0, en: 0, sf: 8, spk: spk, aud: spk * 100, busy: 1});
        end
        for (int k = 0; k < 2; k++)
            tbl.push_back('{rst: 0, en: 0, sf: 8, spk: 0, aud: 0, busy: 0});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].sf);
            check3($sformatf("tbl[%0d]", i), tbl[i].spk, tbl[i].aud, tbl[i].busy);
        end

        // Fresh rise from IDLE at freq 8: 8-cycle period.
        step(0, 1, 8);
        check3("f8.rise", 0, 0, 1);
        for (int k = 1; k <= 16; k++) begin
            step(0, 1, 8);
            spk = (k % 8 >= 4) ? 1 : 0;
            check3($sformatf("f8.k%0d", k), spk, spk * 200, 1);
        end
        for (int k = 0; k < 12; k++) step(0, 0, 8);
        check3("f8.idle", 0, 0, 0);

        // Retrigger while the tail counter sits at 3.
        for (int k = 0; k < 21; k++) step(0, 1, 4);
        step(0, 0, 4);
        for (int k = 0; k < 6; k++) step(0, 0, 4);
        check3("retrig.tail", 1, 100, 1);
        step(0, 1, 8);
        check3("retrig.rise", 0, 0, 1);
        for (int k = 1; k <= 24; k++) begin
            step(0, 1, 8);
            spk = (k % 8 >= 4) ? 1 : 0;
            check3($sformatf("retrig.k%0d", k), spk, spk * 200, 1);
        end

        // Reset mid-tone silences on the next cycle.
        step(1, 1, 8);
        check3("rst_mid", 0, 0, 0);
        step(0, 0, 8);
        check3("rst_after", 0, 0, 0);

        // Zero frequency: busy for 20 + 10 cycles, silent throughout.
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 0);
            check3($sformatf("f0.tone%0d", k), 0, 0, 1);
        end
        for (int k = 0; k < TAIL_N; k++) begin
            step(0, 0, 0);
            check3($sformatf("f0.tail%0d", k), 0, 0, 1);
        end
        step(0, 0, 0);
        check3("f0.idle", 0, 0, 0);

        // One-cycle pulse: one TONE cycle then a full tail.
        step(0, 1, 4);
        check3("pulse.tone", 0, 0, 1);
        for (int k = 1; k <= TAIL_N; k++) begin
            step(0, 0, 4);
            spk = (k % 16 >= 8) ? 1 : 0;
            check3($sformatf("pulse.tail%0d", k), spk, spk * 100, 1);
        end
        step(0, 0, 4);
        check3("pulse.idle", 0, 0, 0);

`ifdef SOUND_OCTAVE_CHIRP_EN
        // After 32 tone cycles the period halves from 16 to 8.
        step(0, 1, 4);
        for (int k = 1; k <= 48; k++) begin
            step(0, 1, 4);
            if (k > CHIRP_N) begin
                spk = (k % 8 >= 4) ? 1 : 0;
                check3($sformatf("chirp.k%0d", k), spk, spk * 200, 1);
            end
        end
        step(1, 0, 0);
`endif

        // Random stimulus against the reference model.
        step(1, 0, 0);
        check_model("rnd.reset");
        en_r = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) en_r = ~en_r;
            step(($urandom_range(0, 599) == 0), en_r, int'($urandom_range(0, 1023)));
            check_model($sformatf("rnd[%0d]", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sound_tone_player.md
Name: sound_tone_player

Overview:
- Consumer end of the game controller's sound interface.
- Samples `enable_sound` and `sound_freq` and synthesises a square-wave tone via a phase accumulator (DDS).
- Drives the 1-bit speaker pin and an amplitude word for the audio codec path.
- Adds a short half-volume release tail after `enable_sound` drops, so win/lose buzzes do not click off.

Parameters:
- ACC_W, 32, phase accumulator width in bits.
- FREQ_W, 10, width of `sound_freq` in Hz; matches the controller's frequency output.
- PHASE_INC_PER_HZ, 86, accumulator increment per Hz per clock (round(2^32/50 MHz)).
- AMP, 8'd200, full-scale amplitude word during TONE.
- SAMPLE_W, 8, width of `audio_out`.
- TAIL_CYCLES, 5000000, length of the release tail in clocks (0.1 s at 50 MHz); legal range 1 to 2^26-1.
- CHIRP_CYCLES, 25000000, TONE cycles before the octave step; used only with the optional feature.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- enable_sound, input, 1, level request from the game controller; high for the whole buzz.
- sound_freq, input, FREQ_W, tone frequency in Hz; sampled only on the rising edge of `enable_sound`.
- speaker_bit, output, 1, square-wave pin.
- audio_out, output, SAMPLE_W, unsigned amplitude of the current half-cycle.
- busy, output, 1, high in TONE or TAIL.

Behaviour:
- Decided interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset, on the `clk` edge with `reset`=1, regardless of state:
  - state=IDLE, acc=0, freq_q=0, tail_cnt=0, en_d=0.
  - speaker_bit=0, audio_out=0, busy=0.
  - Reset asserted mid-TONE or mid-TAIL silences output on the next cycle.
- Edge detect:
  - `en_d` registers `enable_sound`.
  - rise = enable_sound & ~en_d; fall = ~enable_sound & en_d.
- Increment inc = freq_q * PHASE_INC_PER_HZ.
  - Computed at ACC_W bits, truncated to ACC_W.
  - Combinational from `freq_q`.
- State machine:
  - IDLE:
    - acc held at 0.
    - On rise: freq_q<=sound_freq, acc<=0, go to TONE.
  - TONE:
    - acc<=acc+inc each cycle, modulo 2^ACC_W, wrapping silently.
    - On fall: tail_cnt<=TAIL_CYCLES-1, go to TAIL; acc keeps running.
  - TAIL:
    - acc keeps running; tail_cnt decrements.
    - At tail_cnt==0 go to IDLE with acc<=0.
    - On rise in TAIL: retrigger, i.e. freq_q<=sound_freq, acc<=0, go to TONE; this has priority over the tail expiring.
- Outputs, combinational from registered state and acc:
  - speaker_bit = acc[ACC_W-1] when state!=IDLE, else 0.
  - audio_out = AMP in TONE and AMP>>1 in TAIL while speaker_bit=1; otherwise 0.
  - busy = (state!=IDLE).
- Latency: rise sampled at clock edge N → state TONE and acc=0 after edge N; first increment at edge N+1.
- Changes to `sound_freq` during TONE or TAIL are ignored.
- freq_q==0: state machine runs normally, but inc=0, so speaker_bit and audio_out stay 0 and busy still follows the state.
- enable_sound pulse of one cycle: TONE lasts exactly 1 cycle, then a full TAIL.

Optional Feature:
- Macro: SOUND_OCTAVE_CHIRP_EN.
- Defined:
  - A TONE-cycle counter chirp_cnt runs; it is cleared on every entry to TONE.
  - Once chirp_cnt reaches CHIRP_CYCLES, inc = 2*(freq_q*PHASE_INC_PER_HZ) until leaving TONE, giving an octave step.
  - TAIL uses the doubled inc if the chirp had triggered.
  - chirp_cnt saturates at CHIRP_CYCLES.
- Undefined: no chirp_cnt logic; inc is constant for the whole sound.

Test Plan (sim overrides: ACC_W=32, PHASE_INC_PER_HZ=2^26, TAIL_CYCLES=10, CHIRP_CYCLES=32, AMP=200):
- Reset, then enable_sound=1 with sound_freq=4:
  - inc=2^28, so acc wraps every 16 cycles.
  - speaker_bit is 0 for 8 cycles then 1 for 8 cycles, repeating.
  - audio_out=200 while speaker_bit is high; busy=1 from the cycle after the rise.
- Drop enable_sound after 40 TONE cycles:
  - busy stays 1 for exactly 10 cycles.
  - audio_out is 100 during high half-cycles.
  - Then IDLE: speaker_bit=0, audio_out=0, busy=0, acc=0.
- Change sound_freq 4→8 mid-TONE: period stays 16 cycles; a new rise after IDLE with freq 8 gives an 8-cycle period.
- Rise at TAIL count 3 with sound_freq=8: state returns to TONE, acc restarts at 0, period becomes 8, tail is abandoned.
- sound_freq=0 with enable high for 20 cycles: busy=1 for 20+10 cycles; speaker_bit and audio_out stay 0 throughout.
- Reset asserted mid-TONE: next cycle all outputs 0 and state IDLE. With SOUND_OCTAVE_CHIRP_EN defined: after 32 TONE cycles at freq 4, the period changes from 16 to 8 cycles.
